ej1_moore_rx: RTL

EJ1_MOORE_RX -- requirements
Module: ej1_moore_rx

---
 rtl/ej1_moore_rx.sv | 103 ++++++++++
 1 files changed

// File: rtl/ej1_moore_rx.sv
// Receiver for the two-bit Moore position code: decodes {B2,B1} to a 2-bit state and turns steps into Up/Down/Err pulses and a signed count.
// Define EJ1_RX_SYNC_EN to place a 2-flop synchronizer on B1/B2, which adds two cycles of latency.
module ej1_moore_rx #(
    parameter int POS_W = 8
) (
    input  logic             Clock,
    input  logic             R,
    input  logic             B1,
    input  logic             B2,
    output logic [1:0]       State,
    output logic             Up,
    output logic             Down,
    output logic             Err,
    output logic             ErrSticky,
    output logic [POS_W-1:0] Pos
);

    localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

    typedef enum logic {
        MODE_PRIME,
        MODE_TRACK
    } mode_t;

    mode_t      mode_reg;
    logic [1:0] code_smp;
    logic [1:0] cur_state;
    logic [1:0] step_delta;

`ifdef EJ1_RX_SYNC_EN
    localparam int SYNC_STAGES = 2;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic [1:0] stage_reg;
            if (gi == 0) begin : g_head
                always_ff @(posedge Clock) begin
                    if (R) stage_reg <= 2'b00;
                    else   stage_reg <= {B2, B1};
                end
            end else begin : g_tail
                always_ff @(posedge Clock) begin
                    if (R) stage_reg <= 2'b00;
                    else   stage_reg <= g_sync[gi-1].stage_reg;
                end
            end
        end
    endgenerate

    assign code_smp = g_sync[SYNC_STAGES-1].stage_reg;
`else
    assign code_smp = {B2, B1};
`endif

    // y1 = B2, y2 = B1 ^ B2; code_smp is packed as {B2,B1}
    assign cur_state  = {code_smp[1], code_smp[1] ^ code_smp[0]};
    assign step_delta = cur_state - State;

    always_ff @(posedge Clock) begin
        if (R) begin
            mode_reg  <= MODE_PRIME;
            State     <= 2'd0;
            Up        <= 1'b0;
            Down      <= 1'b0;
            Err       <= 1'b0;
            ErrSticky <= 1'b0;
            Pos       <= '0;
        end else begin
            Up   <= 1'b0;
            Down <= 1'b0;
            Err  <= 1'b0;
            case (mode_reg)
                MODE_PRIME: begin
                    // First sample only establishes the reference state
                    State    <= cur_state;
                    mode_reg <= MODE_TRACK;
                end
                MODE_TRACK: begin
                    case (step_delta)
                        2'd1: begin
                            State <= cur_state;
                            Up    <= 1'b1;
                            Pos   <= Pos + POS_ONE;
                        end
                        2'd3: begin
                            State <= cur_state;
                            Down  <= 1'b1;
                            Pos   <= Pos - POS_ONE;
                        end
                        2'd2: begin
                            State     <= cur_state;
                            Err       <= 1'b1;
                            ErrSticky <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: mode_reg <= MODE_PRIME;
            endcase
        end
    end

endmodule
